// File: rtl/coded_temp_decoder_pkg.sv
// Shared constants for the coded temperature link: code table, range encodings, FSM states.
// Optional min/max tracking in the top is enabled by CODED_TEMP_MINMAX_EN.
package coded_temp_decoder_pkg;

   localparam logic [7:0] CODE_19 = 8'h01;
   localparam logic [7:0] CODE_20 = 8'h03;
   localparam logic [7:0] CODE_21 = 8'h07;
   localparam logic [7:0] CODE_22 = 8'h0F;
   localparam logic [7:0] CODE_23 = 8'h1F;
   localparam logic [7:0] CODE_24 = 8'h3F;
   localparam logic [7:0] CODE_25 = 8'h7F;
   localparam logic [7:0] CODE_26 = 8'hFF;

   localparam logic [7:0] T_UNDER = 8'd18;
   localparam logic [7:0] T_OVER  = 8'd27;

   localparam logic [1:0] RANGE_IN    = 2'b00;
   localparam logic [1:0] RANGE_UNDER = 2'b01;
   localparam logic [1:0] RANGE_OVER  = 2'b10;

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_SETTLE = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/coded_temp_lut.sv
// Combinational decode of {alert, thermometer code} into temperature, range and a legality flag.
// Alert is only meaningful with the two end codes; any other combination is illegal.
module coded_temp_lut
   import coded_temp_decoder_pkg::*;
(
   input  logic [7:0] code_i,
   input  logic       alert_i,
   output logic [7:0] temp_o,
   output logic [1:0] range_o,
   output logic       legal_o
);

   always_comb begin
      temp_o  = 8'd0;
      range_o = RANGE_IN;
      legal_o = 1'b1;
      if (alert_i) begin
         if (code_i == CODE_19) begin
            temp_o  = T_UNDER;
            range_o = RANGE_UNDER;
         end else if (code_i == CODE_26) begin
            temp_o  = T_OVER;
            range_o = RANGE_OVER;
         end else begin
            legal_o = 1'b0;
         end
      end else begin
         case (code_i)
            CODE_19: temp_o = 8'd19;
            CODE_20: temp_o = 8'd20;
            CODE_21: temp_o = 8'd21;
            CODE_22: temp_o = 8'd22;
            CODE_23: temp_o = 8'd23;
            CODE_24: temp_o = 8'd24;
            CODE_25: temp_o = 8'd25;
            CODE_26: temp_o = 8'd26;
            default: legal_o = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/coded_temp_decoder.sv
// Receive side of the coded temperature link: registered decode, stability filter, publish FSM,
// saturating link-error counter. CODED_TEMP_MINMAX_EN adds min_temp_o/max_temp_o tracking.
module coded_temp_decoder
   import coded_temp_decoder_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] coded_i,
   input  logic       alert_i,
   input  logic       valid_i,
   output logic [7:0] temp_o,
   output logic [1:0] range_o,
   output logic       temp_valid_o,
   output logic       locked_o,
   output logic       code_err_o,
   output logic [7:0] err_cnt_o
`ifdef CODED_TEMP_MINMAX_EN
   ,
   output logic [7:0] min_temp_o,
   output logic [7:0] max_temp_o
`endif
);

   localparam logic [3:0] STABLE = 4'(STABLE_CNT);

   logic [7:0] lut_temp;
   logic [1:0] lut_range;
   logic       lut_legal;

   logic       s1_valid_q, s1_legal_q;
   logic [7:0] s1_temp_q;
   logic [1:0] s1_range_q;

   logic [7:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] temp_q;
   logic [1:0] range_q;
   logic       temp_valid_q, code_err_q;
   logic [7:0] err_cnt_q;
   state_t     state_q, state_d;
   logic       publish, run_done;

   coded_temp_lut u_lut (
      .code_i  (coded_i),
      .alert_i (alert_i),
      .temp_o  (lut_temp),
      .range_o (lut_range),
      .legal_o (lut_legal)
   );

   // Filter: cnt_q==0 marks "no run in progress", so an illegal sample forces the next run to restart.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      publish  = 1'b0;
      run_done = 1'b0;
      if (s1_valid_q) begin
         if (!s1_legal_q) begin
            cnt_d = 4'd0;
         end else if (cnt_q != 4'd0 && s1_temp_q == cand_q) begin
            cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
         end else begin
            cand_d = s1_temp_q;
            cnt_d  = 4'd1;
         end
         if (s1_legal_q && cnt_d == STABLE) begin
            if (state_q == S_EMPTY || s1_temp_q != temp_q) publish  = 1'b1;
            else                                            run_done = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY:  if (publish) state_d = S_LOCKED;
         S_LOCKED: begin
            if (publish)
               state_d = S_LOCKED;
            else if (s1_valid_q && (!s1_legal_q || s1_temp_q != temp_q))
               state_d = S_SETTLE;
         end
         S_SETTLE: if (publish || run_done) state_d = S_LOCKED;
         default:  state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      locked_o = (state_q == S_LOCKED);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q   <= 1'b0;
         s1_legal_q   <= 1'b0;
         s1_temp_q    <= 8'd0;
         s1_range_q   <= RANGE_IN;
         cand_q       <= 8'd0;
         cnt_q        <= 4'd0;
         temp_q       <= 8'd0;
         range_q      <= RANGE_IN;
         temp_valid_q <= 1'b0;
         code_err_q   <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            s1_legal_q <= lut_legal;
            s1_temp_q  <= lut_temp;
            s1_range_q <= lut_range;
         end
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         temp_valid_q <= publish;
         if (publish) begin
            temp_q  <= s1_temp_q;
            range_q <= s1_range_q;
         end
         code_err_q <= s1_valid_q && !s1_legal_q;
         if (s1_valid_q && !s1_legal_q && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

`ifdef CODED_TEMP_MINMAX_EN
   logic [7:0] min_q, max_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_q <= 8'hFF;
         max_q <= 8'h00;
      end else if (publish) begin
         if (s1_temp_q < min_q) min_q <= s1_temp_q;
         if (s1_temp_q > max_q) max_q <= s1_temp_q;
      end
   end

   assign min_temp_o = min_q;
   assign max_temp_o = max_q;
`endif

   assign temp_o       = temp_q;
   assign range_o      = range_q;
   assign temp_valid_o = temp_valid_q;
   assign code_err_o   = code_err_q;
   assign err_cnt_o    = err_cnt_q;

endmodule
